// File: rtl/ctl_pkg.sv
// Shared types and helpers for the reload/ammunition controller.
// Holds the magazine state encoding and the reload-counter width rule.
package ctl_pkg;

    typedef enum logic [1:0] {
        READY     = 2'd0,
        EMPTY     = 2'd1,
        RELOADING = 2'd2
    } mag_state_t;

    // A reload counter never collapses below one bit, even for RELOAD_CYCLES = 1.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ctl_magazine_ch.sv
// One player channel: request synchroniser, edge detect, link-presence
// tracking and the READY/EMPTY/RELOADING magazine state machine.
module ctl_magazine_ch
    import ctl_pkg::*;
#(
    parameter int AMMO_MAX      = 3,
    parameter int RELOAD_CYCLES = 16,
    parameter int LINK_TIMEOUT  = 64,
    parameter bit ACTIVE_LOW    = 1'b0,
    parameter int AMMO_W        = $clog2(AMMO_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_raw,
    input  logic              shot,
    output logic [AMMO_W-1:0] ammo,
    output logic              can_fire,
    output logic              reloading,
    output logic              reload_done,
    output logic              connected,
    output mag_state_t        state
);

    localparam int CW = cnt_width(RELOAD_CYCLES);
    localparam int LW = $clog2(LINK_TIMEOUT + 1);
    localparam logic [AMMO_W-1:0] AMMO_FULL   = AMMO_W'(AMMO_MAX);
    localparam logic [CW-1:0]     RELOAD_LOAD = CW'(RELOAD_CYCLES - 1);
    localparam logic [LW-1:0]     LINK_LIMIT  = LW'(LINK_TIMEOUT);

    logic              sync1, sync2, req_last;
    logic              req_n, req_n_ahead, req_acc;
    logic [LW-1:0]     run_cnt, run_cnt_nx;
    logic              connected_nx;
    mag_state_t        state_nx;
    logic [AMMO_W-1:0] ammo_nx, ammo_shot;
    logic [CW-1:0]     rl_cnt, rl_cnt_nx;
    logic              done_nx;

    assign req_n       = sync2 ^ ACTIVE_LOW;
    assign req_n_ahead = sync1 ^ ACTIVE_LOW;
    assign req_acc     = req_n & ~req_last & connected;

    // connected rises on the edge sync2 turns idle, so the set term looks at sync1.
    always_comb begin
        run_cnt_nx = run_cnt;
        if (!req_n) begin
            run_cnt_nx = '0;
        end else if (run_cnt != LINK_LIMIT) begin
            run_cnt_nx = run_cnt + 1'b1;
        end
        connected_nx = connected;
        if (!req_n_ahead) begin
            connected_nx = 1'b1;
        end else if (run_cnt_nx == LINK_LIMIT) begin
            connected_nx = 1'b0;
        end
    end

    always_comb begin
        state_nx  = state;
        ammo_nx   = ammo;
        rl_cnt_nx = rl_cnt;
        done_nx   = 1'b0;
        ammo_shot = ammo;
        unique case (state)
            READY: begin
                // The shot lands first; a simultaneous request then sees the reduced count.
                if (shot && (ammo != '0)) begin
                    ammo_shot = ammo - 1'b1;
                end
                ammo_nx = ammo_shot;
                if (req_acc && (ammo_shot < AMMO_FULL)) begin
                    state_nx  = RELOADING;
                    rl_cnt_nx = RELOAD_LOAD;
                end else if (ammo_shot == '0) begin
                    state_nx = EMPTY;
                end
            end
            EMPTY: begin
                if (req_acc && (ammo < AMMO_FULL)) begin
                    state_nx  = RELOADING;
                    rl_cnt_nx = RELOAD_LOAD;
                end
            end
            RELOADING: begin
                if (rl_cnt == '0) begin
                    ammo_nx  = AMMO_FULL;
                    done_nx  = 1'b1;
                    state_nx = READY;
                end else begin
                    rl_cnt_nx = rl_cnt - 1'b1;
                end
            end
            default: state_nx = READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1       <= ACTIVE_LOW;
            sync2       <= ACTIVE_LOW;
            req_last    <= 1'b0;
            run_cnt     <= '0;
            connected   <= 1'b0;
            state       <= READY;
            ammo        <= AMMO_FULL;
            rl_cnt      <= '0;
            can_fire    <= 1'b1;
            reloading   <= 1'b0;
            reload_done <= 1'b0;
        end else begin
            sync1       <= req_raw;
            sync2       <= sync1;
            req_last    <= req_n;
            run_cnt     <= run_cnt_nx;
            connected   <= connected_nx;
            state       <= state_nx;
            ammo        <= ammo_nx;
            rl_cnt      <= rl_cnt_nx;
            can_fire    <= (state_nx == READY);
            reloading   <= (state_nx == RELOADING);
            reload_done <= done_nx;
        end
    end

endmodule

// File: rtl/ctl_magazine.sv
// Per-player reload and ammunition controller: N_CH independent channels,
// with buses sliced per channel; mag_state exposes each channel's FSM state.
module ctl_magazine
    import ctl_pkg::*;
#(
    parameter int              N_CH            = 2,
    parameter int              AMMO_MAX        = 3,
    parameter int              RELOAD_CYCLES   = 16,
    parameter int              LINK_TIMEOUT    = 64,
    parameter logic [N_CH-1:0] ACTIVE_LOW_MASK = 2'b10,
    localparam int             AMMO_W          = $clog2(AMMO_MAX + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH-1:0]        req_raw,
    input  logic [N_CH-1:0]        shot,
    output logic [N_CH*AMMO_W-1:0] ammo,
    output logic [N_CH-1:0]        can_fire,
    output logic [N_CH-1:0]        reloading,
    output logic [N_CH-1:0]        reload_done,
    output logic [N_CH-1:0]        connected,
    output logic [N_CH*2-1:0]      mag_state
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        mag_state_t ch_state;

        ctl_magazine_ch #(
            .AMMO_MAX      (AMMO_MAX),
            .RELOAD_CYCLES (RELOAD_CYCLES),
            .LINK_TIMEOUT  (LINK_TIMEOUT),
            .ACTIVE_LOW    (ACTIVE_LOW_MASK[i]),
            .AMMO_W        (AMMO_W)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .req_raw     (req_raw[i]),
            .shot        (shot[i]),
            .ammo        (ammo[i*AMMO_W +: AMMO_W]),
            .can_fire    (can_fire[i]),
            .reloading   (reloading[i]),
            .reload_done (reload_done[i]),
            .connected   (connected[i]),
            .state       (ch_state)
        );

        assign mag_state[i*2 +: 2] = ch_state;
    end

endmodule
